// File: rtl/vx_ifetch_buffer_if.sv
// Valid/ready instruction channel (warp id, thread mask, PC, instruction word)
// used on both the fetch-response and decode sides of the instruction buffer.
interface vx_ifetch_buffer_if #(
    parameter int WID_W       = 2,
    parameter int NUM_THREADS = 4
);
    logic                   valid;
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            PC;
    logic [31:0]            instr;
    logic                   ready;

    modport master (output valid, wid, tmask, PC, instr, input ready);
    modport slave  (input valid, wid, tmask, PC, instr, output ready);
endinterface

// File: rtl/vx_ifetch_buffer.sv
// Per-warp instruction buffer between fetch and decode: one circular FIFO per warp,
// round-robin output arbitration held stable under back-pressure, per-warp flush.
module vx_ifetch_buffer #(
    parameter int CORE_ID     = 0,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int DEPTH       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    vx_ifetch_buffer_if.slave            in_if,
    vx_ifetch_buffer_if.master           out_if,
    input  logic                         flush_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] flush_wid,
    output logic                         busy
);
    localparam int WID_W   = $clog2(NUM_WARPS);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = NUM_THREADS + 64;

    typedef logic [ENTRY_W-1:0] entry_t;

    // CORE_ID only tags the instance for debug/trace; no hardware depends on it.
    if (CORE_ID < 0) begin : g_core_id_unused
    end

    entry_t           mem_q      [NUM_WARPS][DEPTH];
    entry_t           mem_d      [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0] rd_ptr_q   [NUM_WARPS];
    logic [PTR_W-1:0] rd_ptr_d   [NUM_WARPS];
    logic [PTR_W-1:0] wr_ptr_q   [NUM_WARPS];
    logic [PTR_W-1:0] wr_ptr_d   [NUM_WARPS];
    logic [CNT_W-1:0] count_q    [NUM_WARPS];
    logic [CNT_W-1:0] count_d    [NUM_WARPS];
    logic [WID_W-1:0] rr_q, rr_d, lock_wid_q, lock_wid_d;
    logic             lock_q, lock_d, busy_q, busy_d;

    logic [NUM_WARPS-1:0] cand_s;
    logic                 in_ready_s, push_s, pop_s, lock_hold_s, grant_valid_s;
    logic [WID_W-1:0]     grant_s, idx_s;
    entry_t               head_s;

    // Admission check and arbitration candidates; a warp being flushed is never a candidate.
    always_comb begin
        in_ready_s  = (count_q[in_if.wid] != CNT_W'(DEPTH));
        push_s      = in_if.valid && in_ready_s && !(flush_valid && (flush_wid == in_if.wid));
        lock_hold_s = lock_q && !(flush_valid && (flush_wid == lock_wid_q));
        for (int w = 0; w < NUM_WARPS; w++) begin
            cand_s[w] = (count_q[w] != {CNT_W{1'b0}}) && !(flush_valid && (flush_wid == WID_W'(w)));
        end
    end

    // Grant: locked warp if still valid, else first candidate after the last popped warp.
    always_comb begin
        grant_s       = {WID_W{1'b0}};
        grant_valid_s = 1'b0;
        idx_s         = {WID_W{1'b0}};
        if (lock_hold_s) begin
            grant_s       = lock_wid_q;
            grant_valid_s = 1'b1;
        end else begin
            // Walk from lowest to highest priority so the nearest candidate wins last.
            for (int i = NUM_WARPS; i >= 1; i--) begin
                idx_s         = rr_q + WID_W'(i);
                grant_s       = cand_s[idx_s] ? idx_s : grant_s;
                grant_valid_s = grant_valid_s | cand_s[idx_s];
            end
        end
    end

    assign head_s      = mem_q[grant_s][rd_ptr_q[grant_s]];
    assign pop_s       = grant_valid_s && out_if.ready;
    assign in_if.ready = in_ready_s;
    assign busy        = busy_q;

    // Decode-side outputs, zeroed whenever nothing is offered.
    always_comb begin
        out_if.valid = grant_valid_s;
        if (grant_valid_s) begin
            out_if.wid                               = grant_s;
            {out_if.tmask, out_if.PC, out_if.instr} = head_s;
        end else begin
            out_if.wid                               = {WID_W{1'b0}};
            {out_if.tmask, out_if.PC, out_if.instr} = {ENTRY_W{1'b0}};
        end
    end

    // Next-state for FIFOs, round-robin pointer, lock and busy.
    always_comb begin
        logic inc_v;
        logic dec_v;
        inc_v      = 1'b0;
        dec_v      = 1'b0;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_wid_d = lock_wid_q;
        busy_d     = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc_v = push_s && (in_if.wid == WID_W'(w));
            dec_v = pop_s && (grant_s == WID_W'(w));
            if (flush_valid && (flush_wid == WID_W'(w))) begin
                count_d[w]  = {CNT_W{1'b0}};
                rd_ptr_d[w] = wr_ptr_q[w];
            end else begin
                if (inc_v) begin
                    mem_d[w][wr_ptr_q[w]] = {in_if.tmask, in_if.PC, in_if.instr};
                    wr_ptr_d[w]           = wr_ptr_q[w] + PTR_W'(1'b1);
                end else begin
                    wr_ptr_d[w] = wr_ptr_q[w];
                end
                if (dec_v) begin
                    rd_ptr_d[w] = rd_ptr_q[w] + PTR_W'(1'b1);
                end else begin
                    rd_ptr_d[w] = rd_ptr_q[w];
                end
                case ({inc_v, dec_v})
                    2'b10:   count_d[w] = count_q[w] + CNT_W'(1'b1);
                    2'b01:   count_d[w] = count_q[w] - CNT_W'(1'b1);
                    default: count_d[w] = count_q[w];
                endcase
            end
            busy_d = busy_d | (count_d[w] != {CNT_W{1'b0}});
        end
        // Offered but not taken: hold the grant until the handshake.
        if (pop_s) begin
            lock_d = 1'b0;
            rr_d   = grant_s;
        end else if (grant_valid_s) begin
            lock_d     = 1'b1;
            lock_wid_d = grant_s;
        end else begin
            lock_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[w][e] <= {ENTRY_W{1'b0}};
                end
                rd_ptr_q[w] <= {PTR_W{1'b0}};
                wr_ptr_q[w] <= {PTR_W{1'b0}};
                count_q[w]  <= {CNT_W{1'b0}};
            end
            rr_q       <= {WID_W{1'b0}};
            lock_q     <= 1'b0;
            lock_wid_q <= {WID_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_wid_q <= lock_wid_d;
            busy_q     <= busy_d;
        end
    end
endmodule
